// File: rtl/dpram_rw_pipe_if.sv
`default_nettype none
// ------------------------------------------------------------------
// dpram_rw_pipe_if : read / write / clear port bundle for dpram_rw_pipe
// Revision 1.0
// ------------------------------------------------------------------
interface dpram_rw_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int DATA_DEPTH = 256
);
  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int AW     = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  logic                  clr_req;
  logic                  busy;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [NBYTES-1:0]     wr_be;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output clr_req, rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data,
    input  busy, rd_data, rd_valid
  );

  modport slave (
    input  clr_req, rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data,
    output busy, rd_data, rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/dpram_rw_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// dpram_rw_pipe : byte-enable dual-port RAM, 1/2-stage read, clear sweep
// Revision 1.0
// ------------------------------------------------------------------
module dpram_rw_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int DATA_DEPTH     = 256,
  parameter int RD_LATENCY     = 1,
  parameter int WRITE_FIRST    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           rst,
  dpram_rw_pipe_if.slave bus
);
  localparam int              NBYTES    = DATA_WIDTH / BYTE_WIDTH;
  localparam int              AW        = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_EXT = (AW+1)'(DATA_DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DATA_DEPTH - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  generate
    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
      $error("dpram_rw_pipe: RD_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
      $error("dpram_rw_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
  endgenerate

  state_t                state_q, state_d;
  logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
  logic                  rd_in_range, wr_in_range, rd_go, wr_go;
  logic [AW-1:0]         rd_idx;

  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_EXT);
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_EXT);
  assign rd_go       = (state_q == IDLE) && bus.rd_en;
  assign wr_go       = (state_q == IDLE) && bus.wr_en && wr_in_range;
  assign rd_idx      = rd_in_range ? bus.rd_addr : '0;
  assign bus.busy    = (state_q == CLEAR);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) state_d = CLEAR;
      end
      CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The sweep owns the write port while clearing; user writes only reach it from IDLE.
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [NBYTES-1:0]     mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    if (state_q == CLEAR) begin
      mem_we    = !rst;
      mem_waddr = clr_cnt_q;
      mem_be    = '1;
      mem_wdata = '0;
    end else begin
      mem_we    = !rst && wr_go;
      mem_waddr = bus.wr_addr;
      mem_be    = bus.wr_be;
      mem_wdata = bus.wr_data;
    end
  end

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] rd_word_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (mem_be[i]) mem[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Array read returns pre-write contents; write-first lanes are patched from the captured write.
  always_ff @(posedge clk) begin
    if (rd_go) rd_word_q <= mem[rd_idx];
  end

  logic                  zero_q, zero_d;
  logic [NBYTES-1:0]     coll_be_q, coll_be_d;
  logic [DATA_WIDTH-1:0] coll_data_q, coll_data_d;
  logic                  v1_q, v1_d;
  logic [DATA_WIDTH-1:0] s1_data;

  always_comb begin
    zero_d      = zero_q;
    coll_be_d   = coll_be_q;
    coll_data_d = coll_data_q;
    v1_d        = rd_go;
    if (rd_go) begin
      zero_d      = !rd_in_range;
      coll_be_d   = ((WRITE_FIRST != 0) && wr_go && (bus.wr_addr == bus.rd_addr)) ? bus.wr_be : '0;
      coll_data_d = bus.wr_data;
    end
  end

  always_comb begin
    s1_data = '0;
    if (!zero_q) begin
      for (int i = 0; i < NBYTES; i++) begin
        s1_data[i*BYTE_WIDTH +: BYTE_WIDTH] = coll_be_q[i] ? coll_data_q[i*BYTE_WIDTH +: BYTE_WIDTH]
                                                           : rd_word_q[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      zero_q      <= 1'b1;
      coll_be_q   <= '0;
      coll_data_q <= '0;
      v1_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      zero_q      <= zero_d;
      coll_be_q   <= coll_be_d;
      coll_data_q <= coll_data_d;
      v1_q        <= v1_d;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
      logic                  v2_q, v2_d;

      always_comb begin
        v2_d  = v1_q;
        rd2_d = v1_q ? s1_data : rd2_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd2_q <= '0;
          v2_q  <= 1'b0;
        end else begin
          rd2_q <= rd2_d;
          v2_q  <= v2_d;
        end
      end

      assign bus.rd_data  = rd2_q;
      assign bus.rd_valid = v2_q;
    end else begin : g_lat1
      assign bus.rd_data  = s1_data;
      assign bus.rd_valid = v1_q;
    end
  endgenerate
endmodule
`default_nettype wire

// File: doc/dpram_rw_pipe.md
# dpram_rw_pipe

Parametrised dual-port RAM with one synchronous read port and one synchronous write port, sharing one clock. It is the successor to the plain read/write dual-port RAM and adds four things: byte-enable writes, a selectable one- or two-stage read pipeline with a valid flag, a defined read-during-write policy, and a sequential clear engine. The clear engine replaces the single-cycle array reset, so the block infers block RAM. It sits behind FIFOs, line buffers and register-file style storage in the datapath.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane; NBYTES = DATA_WIDTH/BYTE_WIDTH
- DATA_DEPTH, 256, number of words; need not be a power of two; AW = $clog2(DATA_DEPTH)
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2, anything else is an elaboration error
- WRITE_FIRST, 1, collision policy: 1 means a read sees same-cycle write data, 0 means it sees old data
- CLEAR_ON_RESET, 1, 1 means the block runs a clear sweep after reset
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- clr_req  input  1  single-cycle request to zero the whole array
- busy  output  1  clear sweep in progress; the ports are ignored while high
- rd_en  input  1  read request
- rd_addr  input  AW  read address
- rd_data  output  DATA_WIDTH  read data; holds its last value between reads
- rd_valid  output  1  one-cycle strobe marking new rd_data
- wr_en  input  1  write request
- wr_addr  input  AW  write address
- wr_be  input  NBYTES  byte enables; bit i covers data bits [i*BYTE_WIDTH +: BYTE_WIDTH]
- wr_data  input  DATA_WIDTH  write data

## Operation
- FSM has two states, IDLE and CLEAR. It also owns a clear counter clr_cnt of width AW.
- Reset, asynchronous:
  - rd_data = 0, rd_valid = 0, all pipeline stages invalid, clr_cnt = 0.
  - State = CLEAR and busy = 1 if CLEAR_ON_RESET, otherwise IDLE and busy = 0.
  - Array contents are not reset directly.
- CLEAR state:
  - Each cycle writes all-zero to address clr_cnt, then increments clr_cnt.
  - After writing address DATA_DEPTH-1, the FSM goes to IDLE and clr_cnt returns to 0.
  - clr_req, rd_en and wr_en are ignored.
- IDLE state:
  - clr_req = 1 moves the FSM to CLEAR on the next edge.
  - A user read or write sampled on that same edge is still performed.
- Write, IDLE only: wr_en = 1 updates only the byte lanes whose wr_be bit is 1. wr_be = 0 leaves the word unchanged.
- Read, IDLE only: rd_en = 1 starts a read whose result appears after RD_LATENCY edges.
- Reads already in the pipeline when CLEAR starts still complete and still raise rd_valid.
- Collision (rd_en and wr_en both high, rd_addr == wr_addr):
  - WRITE_FIRST = 1: per lane, rd_data takes wr_data where wr_be = 1 and the old content elsewhere.
  - WRITE_FIRST = 0: rd_data is the old word.
- Out-of-range address (addr >= DATA_DEPTH):
  - Write is dropped.
  - Read returns 0 with rd_valid = 1.
- Reads and writes to different addresses in the same cycle are independent. Back-to-back reads sustain one result per cycle at either latency.

## Timing
- Read with RD_LATENCY = 1: rd_en sampled at edge k gives rd_data and rd_valid = 1 after edge k, for one cycle.
- Read with RD_LATENCY = 2: rd_en sampled at edge k gives rd_data and rd_valid = 1 after edge k+1. The second stage is a plain register.
- Write: data sampled at edge k is visible to a non-colliding read sampled at edge k+1.
- busy:
  - Goes high after the edge that samples clr_req (or from reset).
  - Stays high for exactly DATA_DEPTH cycles.
  - Falls after the edge that writes address DATA_DEPTH-1.
  - The port is usable on the first cycle busy = 0.
- rst asserted mid-sweep: the sweep restarts from address 0 if CLEAR_ON_RESET, otherwise the FSM goes to IDLE and the array is left partially cleared.
- rst asserted mid-read: the in-flight read is discarded and rd_valid stays 0.

## Test plan
- Reset with CLEAR_ON_RESET = 1, DATA_DEPTH = 256 -> busy high for 256 cycles and then low; reading addresses 0..255 afterwards returns 0 with one rd_valid per read.
- Write 0xDEADBEEF to address 5 with wr_be = 4'b1111, then 0x11223344 with wr_be = 4'b0101 -> a read of address 5 returns 0xDE22BE44.
- Same-cycle write 0xAAAAAAAA and read of address 9, which held 0x12345678 -> rd_data = 0xAAAAAAAA when WRITE_FIRST = 1, and 0x12345678 when WRITE_FIRST = 0.
- RD_LATENCY = 2, rd_en high for 4 cycles on addresses 0..3 holding 10, 11, 12, 13 -> rd_valid high for 4 consecutive cycles starting 2 edges after the first request; data 10, 11, 12, 13 in order.
- clr_req at cycle 0 with a read of address 7 on the same edge, plus rd_en/wr_en high during the sweep -> the address-7 read completes with its old value, all sweep-time requests are ignored, and the array is all zero afterwards.
- DATA_DEPTH = 200: write to address 210, then read address 210 -> the write is dropped and the read returns 0 with rd_valid = 1. rst asserted halfway through a sweep -> busy stays high and the sweep restarts for a full 200 cycles.
